mem_access: RTL and testbench

- Memory stage; the producing end of the mem/wb write-back interface.
- Takes the ex-stage result plus an optional load/store, runs byte-serial transactions on an 8-bit memory-controller port, and presents mem_we/mem_waddr/mem_wdata to the mem/wb register.
- Requests a pipeline stall while a memory access is in progress.

---
 rtl/mem_access.sv | 182 ++++++++++++++++++
 tb/tb_mem_access.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory stage: byte-serial load/store engine feeding the mem/wb register.
// Loads and stores are split into 1, 2 or 4 little-endian byte transactions
// on an 8-bit controller port while the pipeline is held by stall_req.
module mem_access #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [31:0]       ex_wdata,
    input  logic [3:0]        ex_memop,
    input  logic [ADDR_W-1:0] ex_maddr,
    input  logic [31:0]       ex_mdata,
    output logic              mem_we,
    output logic [REG_AW-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              stall_req,
    output logic              mc_req,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [7:0]        mc_wdata,
    input  logic              mc_ack,
    input  logic [7:0]        mc_rdata
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_base;
    logic [31:0]         r_sdata;
    logic [1:0]          r_k;
    logic [1:0]          r_last;
    logic [31:0]         r_buf;
    logic                r_mc_req;
    logic                r_mc_wr;
    logic [ADDR_W-1:0]   r_mc_addr;
    logic [7:0]          r_mc_wdata;

    logic                w_valid;
    logic                w_store;
    logic [1:0]          w_last;
    logic [1:0]          w_k_nxt;
    logic [7:0]          w_sbyte_nxt;
    logic                w_is_load;
    logic [31:0]         w_ld_data;

    // Decode the incoming memop: validity, direction and index of the last byte
    always_comb begin
        w_valid = 1'b0;
        w_store = 1'b0;
        w_last  = 2'd0;
        case (ex_memop)
            OP_LB, OP_LBU: begin w_valid = 1'b1; w_last = 2'd0; end
            OP_LH, OP_LHU: begin w_valid = 1'b1; w_last = 2'd1; end
            OP_LW:         begin w_valid = 1'b1; w_last = 2'd3; end
            OP_SB:         begin w_valid = 1'b1; w_store = 1'b1; w_last = 2'd0; end
            OP_SH:         begin w_valid = 1'b1; w_store = 1'b1; w_last = 2'd1; end
            OP_SW:         begin w_valid = 1'b1; w_store = 1'b1; w_last = 2'd3; end
            default:       ;
        endcase
    end

    assign w_k_nxt     = r_k + 2'd1;
    assign w_sbyte_nxt = r_sdata[{w_k_nxt, 3'b000} +: 8];
    assign w_is_load   = (r_op >= OP_LB) && (r_op <= OP_LHU);

    // Size/sign extension of the assembled load buffer
    always_comb begin
        w_ld_data = r_buf;
        case (r_op)
            OP_LB:   w_ld_data = {{24{r_buf[7]}}, r_buf[7:0]};
            OP_LH:   w_ld_data = {{16{r_buf[15]}}, r_buf[15:0]};
            OP_LBU:  w_ld_data = {24'd0, r_buf[7:0]};
            OP_LHU:  w_ld_data = {16'd0, r_buf[15:0]};
            default: w_ld_data = r_buf;
        endcase
    end

    // Transaction FSM with registered controller-port outputs; rdy=0 freezes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_op       <= 4'd0;
            r_base     <= '0;
            r_sdata    <= 32'd0;
            r_k        <= 2'd0;
            r_last     <= 2'd0;
            r_buf      <= 32'd0;
            r_mc_req   <= 1'b0;
            r_mc_wr    <= 1'b0;
            r_mc_addr  <= '0;
            r_mc_wdata <= 8'd0;
        end else if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_op       <= ex_memop;
                        r_base     <= ex_maddr;
                        r_sdata    <= ex_mdata;
                        r_last     <= w_last;
                        r_k        <= 2'd0;
                        r_buf      <= 32'd0;
                        r_mc_req   <= 1'b1;
                        r_mc_wr    <= w_store;
                        r_mc_addr  <= ex_maddr;
                        r_mc_wdata <= ex_mdata[7:0];
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (mc_ack && r_mc_req) begin
                        if (!r_mc_wr) begin
                            r_buf[{r_k, 3'b000} +: 8] <= mc_rdata;
                        end
                        r_k <= w_k_nxt;
                        if (r_k == r_last) begin
                            r_mc_req <= 1'b0;
                            r_mc_wr  <= 1'b0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_mc_addr  <= r_base + ADDR_W'(w_k_nxt);
                            r_mc_wdata <= w_sbyte_nxt;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write-back and stall outputs follow the state and ex inputs directly
    always_comb begin
        stall_req = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = 32'd0;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        stall_req = 1'b1;
                    end else begin
                        mem_we    = ex_we;
                        mem_waddr = ex_waddr;
                        mem_wdata = ex_wdata;
                    end
                end
                ST_XFER: stall_req = 1'b1;
                ST_DONE: begin
                    mem_we    = ex_we;
                    mem_waddr = ex_waddr;
                    mem_wdata = w_is_load ? w_ld_data : ex_wdata;
                end
                default: ;
            endcase
        end
    end

    assign mc_req   = r_mc_req;
    assign mc_wr    = r_mc_wr;
    assign mc_addr  = r_mc_addr;
    assign mc_wdata = r_mc_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte-addressed memory responder plus scoreboards of
// expected write-back results and expected byte transactions.
module tb_mem_access;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  data;
    } acc_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        is_ld;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_maddr;
    logic [31:0] ex_mdata;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        stall_req;
    logic        mc_req;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata;
    logic        mc_ack;
    logic [7:0]  mc_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [logic [31:0]];
    acc_t act_acc[$];
    acc_t exp_acc[$];
    res_t exp_res[$];
    int   ack_wait  = 0;
    logic stray_ack = 1'b0;

    mem_access dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .ex_memop(ex_memop), .ex_maddr(ex_maddr), .ex_mdata(ex_mdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .stall_req(stall_req),
        .mc_req(mc_req), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_ack(mc_ack), .mc_rdata(mc_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    // Memory controller model: ack after ack_wait idle cycles, frozen by rdy=0
    initial begin
        int cnt;
        cnt = 0;
        mc_ack = 1'b0;
        mc_rdata = 8'd0;
        forever begin
            @(posedge clk); #3;
            if (mc_req && rst) begin
                if (cnt == ack_wait) begin
                    mc_ack = 1'b1;
                    mc_rdata = mem_rd(mc_addr);
                    if (rdy) begin
                        acc_t e;
                        e.addr = mc_addr;
                        e.wr   = mc_wr;
                        e.data = mc_wr ? mc_wdata : mc_rdata;
                        act_acc.push_back(e);
                        if (mc_wr) mem[mc_addr] = mc_wdata;
                        cnt = 0;
                    end
                end else begin
                    mc_ack = stray_ack;
                    if (rdy) cnt++;
                end
            end else begin
                mc_ack = stray_ack;
                cnt = 0;
            end
        end
    end

    // One memory instruction: push expectations, run it to DONE, compare
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic we, input logic [4:0] waddr,
                          input logic [31:0] wdata, input int wt, input int freeze_at,
                          input int freeze_len);
        int n, cyc, exp_cyc;
        logic is_ld, is_st, done;
        logic [31:0] lv, frz_addr;
        res_t r;
        acc_t e;
        n = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
            (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
        is_ld = (op >= 4'd1) && (op <= 4'd5);
        is_st = (op >= 4'd6) && (op <= 4'd8);
        lv = 32'd0;
        for (int k = 0; k < n; k++) begin
            e.addr = addr + 32'(k);
            e.wr   = is_st;
            e.data = is_st ? 8'(sdata >> (8 * k)) : mem_rd(addr + 32'(k));
            exp_acc.push_back(e);
            lv = lv | (32'(e.data) << (8 * k));
        end
        case (op)
            4'd1:    r.wdata = {{24{lv[7]}}, lv[7:0]};
            4'd2:    r.wdata = {{16{lv[15]}}, lv[15:0]};
            4'd4:    r.wdata = {24'd0, lv[7:0]};
            4'd5:    r.wdata = {16'd0, lv[15:0]};
            default: r.wdata = lv;
        endcase
        r.we = we; r.waddr = waddr; r.is_ld = is_ld;
        exp_res.push_back(r);
        act_acc.delete();
        ack_wait = wt;
        ex_memop = op; ex_maddr = addr; ex_mdata = sdata;
        ex_we = we; ex_waddr = waddr; ex_wdata = wdata;
        #1;
        checks++;
        if (stall_req !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL %s issue: stall_req=%b mem_we=%b, expected 1/0", name, stall_req, mem_we);
        end
        cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (freeze_at > 0 && cyc == freeze_at) begin
                rdy = 1'b0;
                frz_addr = mc_addr;
                repeat (freeze_len) begin
                    @(posedge clk); #1; cyc++;
                    checks++;
                    if (mc_addr !== frz_addr || mc_req !== 1'b1 || stall_req !== 1'b1) begin
                        errors++;
                        $display("FAIL %s freeze: addr=%h req=%b stall=%b, expected %h/1/1",
                                 name, mc_addr, mc_req, stall_req, frz_addr);
                    end
                end
                rdy = 1'b1;
            end
            if (!stall_req) done = 1'b1;
        end
        exp_cyc = n * (wt + 1) + 1 + freeze_len;
        checks++;
        if (!done || cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s latency: done=%b cycles=%0d, expected %0d", name, done, cyc, exp_cyc);
        end
        r = exp_res.pop_front();
        checks++;
        if (mem_we !== r.we || mem_waddr !== r.waddr || (r.is_ld && mem_wdata !== r.wdata)) begin
            errors++;
            $display("FAIL %s result: we=%b waddr=%0d wdata=%h, expected %b/%0d/%h",
                     name, mem_we, mem_waddr, mem_wdata, r.we, r.waddr, r.wdata);
        end
        checks++;
        if (act_acc.size() != exp_acc.size()) begin
            errors++;
            $display("FAIL %s access count: got %0d, expected %0d", name, act_acc.size(), exp_acc.size());
        end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front();
            if (act_acc.size() > 0) begin
                acc_t a;
                a = act_acc.pop_front();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s access: addr=%h wr=%b data=%h, expected %h/%b/%h",
                             name, a.addr, a.wr, a.data, e.addr, e.wr, e.data);
                end
            end
        end
        ex_memop = 4'd0;
        @(posedge clk); #1;
        checks++;
        if (stall_req !== 1'b0 || mc_req !== 1'b0 || mem_wdata !== ex_wdata) begin
            errors++;
            $display("FAIL %s return idle: stall=%b req=%b wdata=%h, expected 0/0/%h",
                     name, stall_req, mc_req, mem_wdata, ex_wdata);
        end
    endtask

    task automatic test_reset();
        ex_we = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'hDEAD_BEEF; ex_memop = 4'd3;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_waddr !== 5'd0 || mem_wdata !== 32'd0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: we=%b waddr=%0d wdata=%h stall=%b, expected all 0",
                     mem_we, mem_waddr, mem_wdata, stall_req);
        end
        checks++;
        if (mc_req !== 1'b0 || mc_wr !== 1'b0 || mc_addr !== 32'd0 || mc_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset mc: req=%b wr=%b addr=%h wdata=%h, expected all 0",
                     mc_req, mc_wr, mc_addr, mc_wdata);
        end
        ex_memop = 4'd0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_passthrough();
        ex_memop = 4'd0; ex_we = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h0000_1234;
        stray_ack = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_waddr !== 5'd5 || mem_wdata !== 32'h1234 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL passthrough: we=%b waddr=%0d wdata=%h stall=%b, expected 1/5/00001234/0",
                     mem_we, mem_waddr, mem_wdata, stall_req);
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (mc_req !== 1'b0 || stall_req !== 1'b0) begin
                errors++;
                $display("FAIL passthrough stray ack: req=%b stall=%b, expected 0/0", mc_req, stall_req);
            end
        end
        stray_ack = 1'b0;
        ex_memop = 4'd12; ex_waddr = 5'd17; ex_wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b1 || mem_waddr !== 5'd17 || mem_wdata !== 32'hCAFE_0001 ||
            stall_req !== 1'b0 || mc_req !== 1'b0) begin
            errors++;
            $display("FAIL memop 12 as none: we=%b waddr=%0d wdata=%h stall=%b req=%b",
                     mem_we, mem_waddr, mem_wdata, stall_req, mc_req);
        end
        ex_memop = 4'd0;
    endtask

    task automatic test_loads();
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h3] = 8'h80;
        run_op("lw",  4'd3, 32'h100, 32'd0, 1'b1, 5'd7, 32'h0, 1, 0, 0);
        run_op("lb",  4'd1, 32'h3,   32'd0, 1'b1, 5'd8, 32'h0, 0, 0, 0);
        run_op("lbu", 4'd4, 32'h3,   32'd0, 1'b1, 5'd9, 32'h0, 0, 0, 0);
        run_op("lhu", 4'd5, 32'h102, 32'd0, 1'b1, 5'd10, 32'h0, 2, 0, 0);
    endtask

    task automatic test_store_wrap();
        run_op("sh wrap", 4'd7, 32'hFFFF_FFFF, 32'hAABB_CCDD, 1'b0, 5'd0, 32'h0, 0, 0, 0);
        run_op("lh wrap", 4'd2, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd11, 32'h0, 0, 0, 0);
        run_op("sw",      4'd8, 32'h40, 32'h8899_AABB, 1'b0, 5'd0, 32'h0, 1, 0, 0);
        run_op("lw sw",   4'd3, 32'h40, 32'd0, 1'b1, 5'd12, 32'h0, 0, 0, 0);
    endtask

    task automatic test_rdy_freeze();
        mem[32'h20] = 8'h34; mem[32'h21] = 8'hF2;
        run_op("lh freeze", 4'd2, 32'h20, 32'd0, 1'b1, 5'd13, 32'h0, 1, 2, 3);
    endtask

    task automatic test_back_to_back();
        run_op("b2b sb", 4'd6, 32'h80, 32'h0000_00E7, 1'b0, 5'd0, 32'h0, 0, 0, 0);
        run_op("b2b lb", 4'd1, 32'h80, 32'd0, 1'b1, 5'd14, 32'h0, 0, 0, 0);
        run_op("b2b lw", 4'd3, 32'h7E, 32'd0, 1'b1, 5'd15, 32'h0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int guard;
        ack_wait = 1;
        ex_memop = 4'd3; ex_maddr = 32'h200; ex_we = 1'b1; ex_waddr = 5'd20;
        guard = 0;
        while (mc_addr !== 32'h202 && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        checks++;
        if (mc_addr !== 32'h202 || mc_req !== 1'b1) begin
            errors++;
            $display("FAIL mid-reset reach byte: addr=%h req=%b, expected 00000202/1", mc_addr, mc_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mc_req !== 1'b0 || stall_req !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mid-reset abort: req=%b stall=%b we=%b, expected 0/0/0", mc_req, stall_req, mem_we);
        end
        ex_memop = 4'd0; ex_waddr = 5'd9; ex_wdata = 32'h0000_55AA;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_waddr !== 5'd9 || mem_wdata !== 32'h55AA || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL post-reset passthrough: we=%b waddr=%0d wdata=%h stall=%b",
                     mem_we, mem_waddr, mem_wdata, stall_req);
        end
        @(posedge clk); #1;
        checks++;
        if (mc_req !== 1'b0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL post-reset idle: req=%b stall=%b, expected 0/0", mc_req, stall_req);
        end
        run_op("post-reset lbu", 4'd4, 32'h201, 32'd0, 1'b1, 5'd21, 32'h0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0; ex_memop = 4'd0;
        ex_maddr = 32'd0; ex_mdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_passthrough();
        test_loads();
        test_store_wrap();
        test_rdy_freeze();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
